// File: rtl/vram_pkg.sv
// Shared geometry constants and fill-controller state type for the VRAM fill path.
package vram_pkg;
   localparam int ROW_WORDS  = 40;
   localparam int ROWS       = 480;
   localparam int ADDR_W     = 15;
   localparam int VRAM_WORDS = ROW_WORDS * ROWS;
   localparam int X_W        = 6;
   localparam int Y_W        = 9;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;
endpackage

// File: rtl/vram_fill_addr_gen.sv
// Rectangle walker: latches the fill geometry and produces the current fill
// word address plus a flag marking the final word of the rectangle.
module vram_fill_addr_gen #(
   parameter int ROW_WORDS = vram_pkg::ROW_WORDS,
   parameter int ADDR_W    = vram_pkg::ADDR_W
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     load,
   input  logic                     advance,
   input  logic [vram_pkg::X_W-1:0] cmd_x,
   input  logic [vram_pkg::Y_W-1:0] cmd_y,
   input  logic [vram_pkg::X_W-1:0] cmd_w,
   input  logic [vram_pkg::Y_W-1:0] cmd_h,
   output logic [ADDR_W-1:0]        addr,
   output logic                     last
);
   import vram_pkg::*;

   logic [X_W-1:0]    x_reg;
   logic [X_W-1:0]    w_reg;
   logic [Y_W-1:0]    h_reg;
   logic [X_W-1:0]    col_reg;
   logic [Y_W-1:0]    row_reg;
   logic [ADDR_W-1:0] base_reg;
   logic              col_last;
   logic              row_last;

   assign col_last = (col_reg == w_reg - X_W'(1));
   assign row_last = (row_reg == h_reg - Y_W'(1));
   assign last     = col_last && row_last;
   assign addr     = base_reg + ADDR_W'(x_reg) + ADDR_W'(col_reg);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         x_reg    <= '0;
         w_reg    <= '0;
         h_reg    <= '0;
         col_reg  <= '0;
         row_reg  <= '0;
         base_reg <= '0;
      end else if (load) begin
         x_reg    <= cmd_x;
         w_reg    <= cmd_w;
         h_reg    <= cmd_h;
         col_reg  <= '0;
         row_reg  <= '0;
         base_reg <= ADDR_W'(cmd_y) * ADDR_W'(ROW_WORDS);
      end else if (advance) begin
         // Column wraps at the right edge of the rectangle, stepping one VRAM row down.
         if (col_last) begin
            col_reg  <= '0;
            row_reg  <= row_reg + Y_W'(1);
            base_reg <= base_reg + ADDR_W'(ROW_WORDS);
         end else begin
            col_reg  <= col_reg + X_W'(1);
         end
      end
   end
endmodule

// File: rtl/vram_fill_arbiter.sv
// VRAM write port arbiter: CPU writes always win, rectangle fill writes use
// the remaining cycles. All VRAM outputs are registered.
module vram_fill_arbiter #(
   parameter int ROW_WORDS = vram_pkg::ROW_WORDS,
   parameter int ROWS      = vram_pkg::ROWS,
   parameter int ADDR_W    = vram_pkg::ADDR_W
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     cpu_wr,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [31:0]              cpu_data,
   input  logic [3:0]               cpu_byte_en,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [vram_pkg::X_W-1:0] cmd_x,
   input  logic [vram_pkg::Y_W-1:0] cmd_y,
   input  logic [vram_pkg::X_W-1:0] cmd_w,
   input  logic [vram_pkg::Y_W-1:0] cmd_h,
   input  logic [31:0]              cmd_pattern,
   input  logic                     abort,
   output logic                     vram_wren,
   output logic [ADDR_W-1:0]        vram_addr,
   output logic [31:0]              vram_data,
   output logic [3:0]               vram_byte_en,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   import vram_pkg::*;

   state_t            state_reg;
   state_t            state_next;
   logic [31:0]       pattern_reg;
   logic [31:0]       x_end;
   logic [31:0]       y_end;
   logic              cmd_ok;
   logic              cmd_accept;
   logic              cmd_reject;
   logic              fill_fire;
   logic              fill_done;
   logic [ADDR_W-1:0] fill_addr;
   logic              fill_last;

   assign cmd_ready = (state_reg == IDLE);

   // Sums are widened so out-of-range rectangles cannot alias back into range.
   assign x_end  = 32'(cmd_x) + 32'(cmd_w);
   assign y_end  = 32'(cmd_y) + 32'(cmd_h);
   assign cmd_ok = (cmd_w != '0) && (cmd_h != '0)
                   && (x_end <= 32'(ROW_WORDS)) && (y_end <= 32'(ROWS));

   always_comb begin
      state_next = state_reg;
      cmd_accept = 1'b0;
      cmd_reject = 1'b0;
      fill_fire  = 1'b0;
      fill_done  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_ok) begin
                  cmd_accept = 1'b1;
                  state_next = FILL;
               end else begin
                  cmd_reject = 1'b1;
               end
            end
         end
         FILL: begin
            // Abort outranks completion; a CPU write only stalls the walk.
            if (abort) begin
               state_next = IDLE;
            end else if (!cpu_wr) begin
               fill_fire = 1'b1;
               if (fill_last) begin
                  fill_done  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   vram_fill_addr_gen #(
      .ROW_WORDS (ROW_WORDS),
      .ADDR_W    (ADDR_W)
   ) u_addr_gen (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .load    (cmd_accept),
      .advance (fill_fire),
      .cmd_x   (cmd_x),
      .cmd_y   (cmd_y),
      .cmd_w   (cmd_w),
      .cmd_h   (cmd_h),
      .addr    (fill_addr),
      .last    (fill_last)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pattern_reg  <= '0;
         vram_wren    <= 1'b0;
         vram_addr    <= '0;
         vram_data    <= '0;
         vram_byte_en <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (cmd_accept) begin
            pattern_reg <= cmd_pattern;
         end
         vram_wren <= cpu_wr | fill_fire;
         if (cpu_wr) begin
            vram_addr    <= cpu_addr;
            vram_data    <= cpu_data;
            vram_byte_en <= cpu_byte_en;
         end else if (fill_fire) begin
            vram_addr    <= fill_addr;
            vram_data    <= pattern_reg;
            vram_byte_en <= 4'hF;
         end
         busy <= (state_next == FILL);
         done <= fill_done;
         err  <= cmd_reject;
      end
   end
endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter: fills, CPU contention, rejection,
// abort and mid-fill reset, each step checked against hand-computed values.
module tb_vram_fill_arbiter;
   logic        CLK;
   logic        RESET_N;
   logic        cpu_wr;
   logic [14:0] cpu_addr;
   logic [31:0] cpu_data;
   logic [3:0]  cpu_byte_en;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [5:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [5:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [31:0] cmd_pattern;
   logic        abort;
   logic        vram_wren;
   logic [14:0] vram_addr;
   logic [31:0] vram_data;
   logic [3:0]  vram_byte_en;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;

   vram_fill_arbiter dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .cpu_wr       (cpu_wr),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .cpu_byte_en  (cpu_byte_en),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_w        (cmd_w),
      .cmd_h        (cmd_h),
      .cmd_pattern  (cmd_pattern),
      .abort        (abort),
      .vram_wren    (vram_wren),
      .vram_addr    (vram_addr),
      .vram_data    (vram_data),
      .vram_byte_en (vram_byte_en),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic issue_cmd(input logic [5:0] x, input logic [8:0] y, input logic [5:0] w,
                            input logic [8:0] h, input logic [31:0] pat);
      cmd_valid   = 1'b1;
      cmd_x       = x;
      cmd_y       = y;
      cmd_w       = w;
      cmd_h       = h;
      cmd_pattern = pat;
      step();
      cmd_valid   = 1'b0;
   endtask

   task automatic expect_fill(input string tag, input logic [14:0] a, input logic [31:0] pat,
                              input logic last);
      step();
      chk({tag, "_wren"}, 32'(vram_wren), 32'(1'b1));
      chk({tag, "_addr"}, 32'(vram_addr), 32'(a));
      chk({tag, "_data"}, vram_data, pat);
      chk({tag, "_be"},   32'(vram_byte_en), 32'h0000000F);
      chk({tag, "_done"}, 32'(done), 32'(last));
      $display("fill write %s addr=0x%04h data=0x%08h done=%0b", tag, vram_addr, vram_data, done);
   endtask

   task automatic expect_idle_out(input string tag);
      chk({tag, "_wren"}, 32'(vram_wren), 32'(1'b0));
      chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
      chk({tag, "_rdy"},  32'(cmd_ready), 32'(1'b1));
   endtask

   initial begin
      RESET_N     = 1'b1;
      cpu_wr      = 1'b0;
      cpu_addr    = '0;
      cpu_data    = '0;
      cpu_byte_en = '0;
      cmd_valid   = 1'b0;
      cmd_x       = '0;
      cmd_y       = '0;
      cmd_w       = '0;
      cmd_h       = '0;
      cmd_pattern = '0;
      abort       = 1'b0;
      #1 RESET_N = 1'b0;
      #1;
      chk("rst_wren", 32'(vram_wren), 32'(1'b0));
      chk("rst_addr", 32'(vram_addr), 32'(1'b0));
      chk("rst_data", vram_data, 32'h0);
      chk("rst_be",   32'(vram_byte_en), 32'(1'b0));
      chk("rst_busy", 32'(busy), 32'(1'b0));
      chk("rst_done", 32'(done), 32'(1'b0));
      chk("rst_err",  32'(err), 32'(1'b0));
      chk("rst_rdy",  32'(cmd_ready), 32'(1'b1));
      step();
      step();
      RESET_N = 1'b1;
      step();
      $display("reset released");

      // CPU write in IDLE to the palette range passes through untouched.
      cpu_wr = 1'b1; cpu_addr = 15'h5000; cpu_data = 32'hDEADBEEF; cpu_byte_en = 4'h9;
      step();
      cpu_wr = 1'b0;
      chk("cpu_idle_wren", 32'(vram_wren), 32'(1'b1));
      chk("cpu_idle_addr", 32'(vram_addr), 32'h5000);
      chk("cpu_idle_data", vram_data, 32'hDEADBEEF);
      chk("cpu_idle_be",   32'(vram_byte_en), 32'h9);
      $display("cpu write addr=0x%04h data=0x%08h be=0x%h", vram_addr, vram_data, vram_byte_en);
      step();
      chk("cpu_idle_after_wren", 32'(vram_wren), 32'(1'b0));

      // Abort while idle does nothing.
      abort = 1'b1;
      step();
      abort = 1'b0;
      expect_idle_out("abort_idle");
      chk("abort_idle_done", 32'(done), 32'(1'b0));
      $display("abort in idle ignored");

      // Single word fill.
      issue_cmd(6'd0, 9'd0, 6'd1, 9'd1, 32'h55555555);
      chk("sw_busy", 32'(busy), 32'(1'b1));
      chk("sw_rdy",  32'(cmd_ready), 32'(1'b0));
      chk("sw_wren0", 32'(vram_wren), 32'(1'b0));
      expect_fill("sw", 15'h0000, 32'h55555555, 1'b1);
      chk("sw_busy_end", 32'(busy), 32'(1'b0));
      chk("sw_rdy_end",  32'(cmd_ready), 32'(1'b1));
      step();
      chk("sw_done_clr", 32'(done), 32'(1'b0));
      chk("sw_wren_clr", 32'(vram_wren), 32'(1'b0));

      // Rectangle touching the right edge wraps to the next row.
      issue_cmd(6'd38, 9'd1, 6'd2, 9'd2, 32'h12345678);
      expect_fill("wrap0", 15'd78,  32'h12345678, 1'b0);
      expect_fill("wrap1", 15'd79,  32'h12345678, 1'b0);
      expect_fill("wrap2", 15'd118, 32'h12345678, 1'b0);
      expect_fill("wrap3", 15'd119, 32'h12345678, 1'b1);
      step();
      expect_idle_out("wrap_end");

      // CPU contention stalls the fill for two cycles.
      issue_cmd(6'd0, 9'd2, 6'd4, 9'd1, 32'hA5A5A5A5);
      expect_fill("cont0", 15'd80, 32'hA5A5A5A5, 1'b0);
      cpu_wr = 1'b1; cpu_addr = 15'h4B01; cpu_data = 32'h00000F00; cpu_byte_en = 4'h5;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("cont_cpu_wren", 32'(vram_wren), 32'(1'b1));
         chk("cont_cpu_addr", 32'(vram_addr), 32'h4B01);
         chk("cont_cpu_data", vram_data, 32'h00000F00);
         chk("cont_cpu_be",   32'(vram_byte_en), 32'h5);
         chk("cont_cpu_busy", 32'(busy), 32'(1'b1));
         chk("cont_cpu_done", 32'(done), 32'(1'b0));
         $display("cpu write during fill addr=0x%04h data=0x%08h", vram_addr, vram_data);
      end
      cpu_wr = 1'b0;
      expect_fill("cont1", 15'd81, 32'hA5A5A5A5, 1'b0);
      expect_fill("cont2", 15'd82, 32'hA5A5A5A5, 1'b0);
      expect_fill("cont3", 15'd83, 32'hA5A5A5A5, 1'b1);
      step();
      expect_idle_out("cont_end");

      // Rejections: overhanging width, then zero height.
      issue_cmd(6'd30, 9'd0, 6'd11, 9'd1, 32'hFFFFFFFF);
      chk("rej_w_err",  32'(err), 32'(1'b1));
      expect_idle_out("rej_w");
      $display("reject x=30 w=11 err=%0b", err);
      step();
      chk("rej_w_err_clr", 32'(err), 32'(1'b0));
      chk("rej_w_wren",    32'(vram_wren), 32'(1'b0));
      issue_cmd(6'd0, 9'd0, 6'd1, 9'd0, 32'hFFFFFFFF);
      chk("rej_h_err", 32'(err), 32'(1'b1));
      expect_idle_out("rej_h");
      $display("reject h=0 err=%0b", err);
      step();
      chk("rej_h_err_clr", 32'(err), 32'(1'b0));
      chk("rej_h_wren",    32'(vram_wren), 32'(1'b0));

      // Largest legal fill, aborted after ten writes.
      issue_cmd(6'd0, 9'd0, 6'd40, 9'd480, 32'h0F0F0F0F);
      for (int i = 0; i < 10; i++) begin
         expect_fill("ab", 15'(i), 32'h0F0F0F0F, 1'b0);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_done", 32'(done), 32'(1'b0));
      expect_idle_out("ab_cut");
      $display("abort after 10 writes busy=%0b wren=%0b", busy, vram_wren);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ab_quiet_wren", 32'(vram_wren), 32'(1'b0));
         chk("ab_quiet_done", 32'(done), 32'(1'b0));
      end

      // Reset in the middle of a fill.
      issue_cmd(6'd4, 9'd3, 6'd4, 9'd2, 32'h33333333);
      expect_fill("rf0", 15'd124, 32'h33333333, 1'b0);
      expect_fill("rf1", 15'd125, 32'h33333333, 1'b0);
      RESET_N = 1'b0;
      #1;
      chk("rf_rst_wren", 32'(vram_wren), 32'(1'b0));
      chk("rf_rst_addr", 32'(vram_addr), 32'(1'b0));
      chk("rf_rst_data", vram_data, 32'h0);
      chk("rf_rst_be",   32'(vram_byte_en), 32'(1'b0));
      chk("rf_rst_busy", 32'(busy), 32'(1'b0));
      chk("rf_rst_done", 32'(done), 32'(1'b0));
      chk("rf_rst_err",  32'(err), 32'(1'b0));
      chk("rf_rst_rdy",  32'(cmd_ready), 32'(1'b1));
      $display("reset asserted mid-fill outputs cleared");
      step();
      RESET_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         expect_idle_out("rf_after");
         chk("rf_after_done", 32'(done), 32'(1'b0));
      end
      $display("after reset release no further fill writes");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
